// File: rtl/fetch_queue.sv
// Registered instruction fetch front end: owns the fetch PC, issues 1-cycle-latency
// memory reads, and buffers {pc, instr} pairs in a small FIFO toward decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    input  logic        ready_in
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_L = DEPTH[CW:0];
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [31:0]   pc_reg;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          stale;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic [CW:0] credit_used;
    logic        issue;
    logic        enq;
    logic        deq;

    // Credit counts the in-flight read as occupied so a response always has a free slot.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue       = !reset && !redirect_valid && (credit_used < DEPTH_L);
    assign enq         = imem_resp_valid && inflight && !stale && !redirect_valid;
    assign deq         = valid_out && ready_in;

    assign imem_req_valid = issue;
    assign imem_req_addr  = pc_reg;

    assign valid_out = (count != '0);
    assign pc_out    = valid_out ? pc_mem[head]    : 32'h0;
    assign instr_out = valid_out ? instr_mem[head] : 32'h0;

    // NOTE: state registers use non-blocking assignments so every update in this
    // block sees the pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg      <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            stale       <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            pc_reg   <= redirect_pc & ~32'h3;
            inflight <= 1'b0;
            stale    <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                pc_reg      <= pc_reg + 32'd4;
                inflight    <= 1'b1;
                inflight_pc <= pc_reg;
            end else begin
                inflight <= 1'b0;
            end
            if (enq) tail <= tail + PTR_ONE;
            if (deq) head <= head + PTR_ONE;
            if (enq && !deq)      count <= count + CNT_ONE;
            else if (!enq && deq) count <= count - CNT_ONE;
        end
    end

    // NOTE: the storage array has no reset; an entry is only observable once
    // count covers it, and the output mux forces zeros while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail]    <= inflight_pc;
            instr_mem[tail] <= imem_resp_data;
        end
    end

    resp_has_request: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> inflight);

    enq_never_full: assert property (@(posedge clk) disable iff (reset)
        enq |-> ({1'b0, count} < DEPTH_L));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue with a 1-cycle instruction memory
// model whose data word is the address XOR a fixed key.
module tb_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        ready_in = 1'b0;

    logic [31:0] resp_addr;

    int n_total = 0;
    int n_pass  = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .valid_out       (valid_out),
        .pc_out          (pc_out),
        .instr_out       (instr_out),
        .ready_in        (ready_in)
    );

    always #5 clk = ~clk;

    // Memory model: answers every request exactly one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_resp_valid <= 1'b0;
            resp_addr       <= 32'h0;
        end else begin
            imem_resp_valid <= imem_req_valid;
            resp_addr       <= imem_req_addr;
        end
    end
    assign imem_resp_data = resp_addr ^ KEY;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rp;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_vo;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rv, input logic [31:0] rp,
                       input logic rdy, input logic exp_req, input logic [31:0] exp_addr,
                       input logic exp_vo, input logic [31:0] exp_pc);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rp = rp; v.rdy = rdy;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_vo = exp_vo; v.exp_pc = exp_pc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_outputs(input string tag, input logic exp_req, input logic [31:0] exp_addr,
                                 input logic exp_vo, input logic [31:0] exp_pc);
        check({tag, " req_valid"}, {31'h0, imem_req_valid}, {31'h0, exp_req});
        check({tag, " req_addr"},  imem_req_addr, exp_addr);
        check({tag, " valid_out"}, {31'h0, valid_out}, {31'h0, exp_vo});
        check({tag, " pc_out"},    pc_out, exp_pc);
        check({tag, " instr_out"}, instr_out, exp_vo ? (exp_pc ^ KEY) : 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst rv rp            rdy req addr          vo pc
        add(1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0);
        // Streaming from reset with decode always ready.
        add(0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0);
        add(0, 0, 32'h0,         1, 1, 32'h4,         0, 32'h0);
        add(0, 0, 32'h0,         1, 1, 32'h8,         1, 32'h0);
        add(0, 0, 32'h0,         1, 1, 32'hC,         1, 32'h4);
        add(0, 0, 32'h0,         1, 1, 32'h10,        1, 32'h8);
        // Back-pressure: fill to DEPTH, hold the head, release one slot.
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0);
        add(0, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0);
        add(0, 0, 32'h0,         0, 1, 32'h4,         0, 32'h0);
        add(0, 0, 32'h0,         0, 1, 32'h8,         1, 32'h0);
        add(0, 0, 32'h0,         0, 1, 32'hC,         1, 32'h0);
        add(0, 0, 32'h0,         0, 0, 32'h10,        1, 32'h0);
        add(0, 0, 32'h0,         0, 0, 32'h10,        1, 32'h0);
        add(0, 0, 32'h0,         0, 0, 32'h10,        1, 32'h0);
        add(0, 0, 32'h0,         1, 0, 32'h10,        1, 32'h0);
        add(0, 0, 32'h0,         0, 1, 32'h10,        1, 32'h4);
        // Redirect while the 0x10 response is returning.
        add(0, 1, 32'h200,       0, 0, 32'h14,        1, 32'h4);
        add(0, 0, 32'h0,         0, 1, 32'h200,       0, 32'h0);
        add(0, 0, 32'h0,         0, 1, 32'h204,       0, 32'h0);
        add(0, 0, 32'h0,         1, 1, 32'h208,       1, 32'h200);
        add(0, 0, 32'h0,         1, 1, 32'h20C,       1, 32'h204);
        add(0, 0, 32'h0,         0, 1, 32'h210,       1, 32'h208);
        add(0, 0, 32'h0,         0, 1, 32'h214,       1, 32'h208);
        // Redirect coinciding with a decode fire while three entries are held.
        add(0, 1, 32'h300,       1, 0, 32'h218,       1, 32'h208);
        add(0, 0, 32'h0,         1, 1, 32'h300,       0, 32'h0);
        add(0, 0, 32'h0,         1, 1, 32'h304,       0, 32'h0);
        add(0, 0, 32'h0,         1, 1, 32'h308,       1, 32'h300);
        add(0, 0, 32'h0,         1, 1, 32'h30C,       1, 32'h304);
        // PC wrap at the top of the address space.
        add(0, 1, 32'hFFFF_FFF8, 1, 0, 32'h310,       1, 32'h308);
        add(0, 0, 32'h0,         1, 1, 32'hFFFF_FFF8, 0, 32'h0);
        add(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0);
        add(0, 0, 32'h0,         1, 1, 32'h0,         1, 32'hFFFF_FFF8);
        add(0, 0, 32'h0,         1, 1, 32'h4,         1, 32'hFFFF_FFFC);
        add(0, 0, 32'h0,         1, 1, 32'h8,         1, 32'h0);
        // Misaligned redirect target is forced onto a word boundary.
        add(0, 1, 32'h103,       1, 0, 32'hC,         1, 32'h4);
        add(0, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0);
        add(0, 0, 32'h0,         1, 1, 32'h104,       0, 32'h0);
        add(0, 0, 32'h0,         1, 1, 32'h108,       1, 32'h100);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset          = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rp;
            ready_in       = vecs[i].rdy;
            #1;
            check_outputs($sformatf("row%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                          vecs[i].exp_vo, vecs[i].exp_pc);
            next_cycle();
        end

        // Asynchronous reset landing between clock edges while streaming.
        redirect_valid = 1'b0;
        ready_in       = 1'b1;
        #3;
        check("pre_reset valid_out", {31'h0, valid_out}, 32'h1);
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        reset = 1'b0;
        #1;
        check_outputs("post_reset c0", 1'b1, 32'h0, 1'b0, 32'h0);
        next_cycle();
        check_outputs("post_reset c1", 1'b1, 32'h4, 1'b0, 32'h0);
        next_cycle();
        check_outputs("post_reset c2", 1'b1, 32'h8, 1'b1, 32'h0);
        next_cycle();
        check_outputs("post_reset c3", 1'b1, 32'hC, 1'b1, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
